// File: rtl/rom_ioctl_pkg.sv
// Shared types for the ioctl ROM download sink: FIFO entry layout, write FSM
// states and the filler byte used for half-populated words.
package rom_ioctl_pkg;

    localparam int         ENTRY_AW  = 24;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [15:0]         data;
        logic [1:0]          be;
    } fifo_entry_t;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } wr_state_t;

    // Single-byte word: even bytes land in [15:8], odd bytes in [7:0].
    function automatic fifo_entry_t make_entry(input logic [ENTRY_AW-1:0] addr,
                                               input logic [7:0]          data,
                                               input logic                odd);
        fifo_entry_t e;
        e.addr = addr;
        if (odd) begin
            e.data = {FILL_BYTE, data};
            e.be   = 2'b01;
        end else begin
            e.data = {data, FILL_BYTE};
            e.be   = 2'b10;
        end
        return e;
    endfunction

endpackage

// File: rtl/ioctl_word_fifo.sv
// Small synchronous FIFO of packed SDRAM word writes; head is read straight
// from the storage registers so a pop can capture it in the same cycle.
module ioctl_word_fifo
    import rom_ioctl_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        push_i,
    input  fifo_entry_t push_data_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int DEPTH = 1 << AW;

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rom_ioctl_sink.sv
// Consumer of the data_io byte stream: packs bytes into big-endian words,
// queues them and writes them to SDRAM with a req/ack handshake.
module rom_ioctl_sink
    import rom_ioctl_pkg::*;
#(
    parameter logic [7:0] INDEX   = 8'd0,
    parameter int         FIFO_AW = 2,
    parameter int         ADDR_W  = 24
) (
    input  logic              clk_96M,
    input  logic              reset,
    input  logic              ioctl_downl,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [15:0]       sdr_data,
    output logic [1:0]        sdr_be,
    input  logic              sdr_ack,
    output logic              busy,
    output logic              rom_loaded,
    output logic              overflow
);

    wr_state_t   state_q, state_d;
    fifo_entry_t pend_q, pend_d;
    fifo_entry_t def_q, def_d;
    fifo_entry_t out_q;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        pend_v_q, pend_v_d;
    logic        def_v_q, def_v_d;
    logic        active_q, active_d;
    logic        downl_prev_q;
    logic        session_q;
    logic        loaded_q, loaded_d;
    logic        overflow_q;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic        wr_ev, start;
    fifo_entry_t byte_entry;

    assign start      = ioctl_downl && !downl_prev_q && (ioctl_index == INDEX);
    assign wr_ev      = active_q && ioctl_downl && ioctl_wr;
    assign byte_entry = make_entry(ioctl_addr[24:1], ioctl_dout, ioctl_addr[0]);

    // Packer: at most one push per cycle; the second push of an event is deferred.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        def_d      = def_q;
        def_v_d    = def_v_q;
        active_d   = active_q;

        if (start) begin
            active_d = 1'b1;
        end else if (active_q && !ioctl_downl) begin
            active_d = 1'b0;
        end

        if (def_v_q) begin
            push       = 1'b1;
            push_entry = def_q;
            def_v_d    = 1'b0;
        end else if (wr_ev) begin
            if (!ioctl_addr[0]) begin
                push       = pend_v_q;
                push_entry = pend_q;
                pend_d     = byte_entry;
                pend_v_d   = 1'b1;
            end else if (pend_v_q && (pend_q.addr == ioctl_addr[24:1])) begin
                push            = 1'b1;
                push_entry      = pend_q;
                push_entry.data = {pend_q.data[15:8], ioctl_dout};
                push_entry.be   = 2'b11;
                pend_v_d        = 1'b0;
            end else if (pend_v_q) begin
                push       = 1'b1;
                push_entry = pend_q;
                pend_v_d   = 1'b0;
                def_d      = byte_entry;
                def_v_d    = 1'b1;
            end else begin
                push       = 1'b1;
                push_entry = byte_entry;
            end
        end else if (!active_q && pend_v_q) begin
            push       = 1'b1;
            push_entry = pend_q;
            pend_v_d   = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sdr_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Judged on next-state values so the flag rises the cycle after the last ack.
    always_comb begin
        loaded_d = loaded_q;
        if (start) begin
            loaded_d = 1'b0;
        end else if (session_q && !active_d && !pend_v_d && !def_v_d &&
                     fifo_empty && !push && (state_d == S_IDLE)) begin
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk_96M) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            def_q        <= '0;
            def_v_q      <= 1'b0;
            out_q        <= '0;
            active_q     <= 1'b0;
            downl_prev_q <= ioctl_downl;
            session_q    <= 1'b0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            def_q        <= def_d;
            def_v_q      <= def_v_d;
            active_q     <= active_d;
            downl_prev_q <= ioctl_downl;
            loaded_q     <= loaded_d;
            if (pop) begin
                out_q <= head;
            end
            if (start) begin
                session_q  <= 1'b1;
                overflow_q <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ioctl_word_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk         (clk_96M),
        .srst        (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign sdr_req    = (state_q == S_REQ);
    assign sdr_addr   = ADDR_W'(out_q.addr);
    assign sdr_data   = out_q.data;
    assign sdr_be     = out_q.be;
    assign busy       = active_q || pend_v_q || def_v_q || !fifo_empty || (state_q == S_REQ);
    assign rom_loaded = loaded_q;
    assign overflow   = overflow_q;

endmodule
